// File: rtl/pong_game_ctrl.sv
// Purpose: frame-rate game sequencer for the VGA ping-pong datapath. It detects
//          wall bounces, paddle hits and misses, keeps both scores, and drives the ball mover.
// Latency: one clk from a frame_tick decision to the registered outputs.
//          Reset is asynchronous and takes effect immediately.
// Backpressure: none. Game state advances only on frame_tick. start_btn edges
//          are latched (start_pend) between ticks while in IDLE/OVER.
// Ports:   clk, reset (async, active-high), frame_tick, start_btn,
//          ball_x/ball_y (signed 11b), paddle_l_y/paddle_r_y (10b) in;
//          ball_rst, ball_move, ball_dir[3:0] ({up,down,left,right}),
//          ball_speed[1:0], score_l/score_r[3:0], state[2:0], winner out.
// Config:  define PONG_SPEEDUP_EN to build the rally counter; ball_speed then
//          steps up every 4 paddle hits. Otherwise ball_speed is tied to 0.
module pong_game_ctrl #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int BALL_SIZE    = 20,
    parameter int PADDLE_W     = 10,
    parameter int PADDLE_H     = 80,
    parameter int PADDLE_L_X   = 20,
    parameter int PADDLE_R_X   = 610,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start_btn,
    input  logic signed [10:0] ball_x,
    input  logic signed [10:0] ball_y,
    input  logic        [9:0]  paddle_l_y,
    input  logic        [9:0]  paddle_r_y,
    output logic               ball_rst,
    output logic               ball_move,
    output logic        [3:0]  ball_dir,
    output logic        [1:0]  ball_speed,
    output logic        [3:0]  score_l,
    output logic        [3:0]  score_r,
    output logic        [2:0]  state,
    output logic               winner
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam logic signed [12:0] BALL     = 13'(BALL_SIZE);
    localparam logic signed [12:0] SCR_W    = 13'(SCREEN_W);
    localparam logic signed [12:0] SCR_H    = 13'(SCREEN_H);
    localparam logic signed [12:0] PAD_H    = 13'(PADDLE_H);
    localparam logic signed [12:0] PAD_L_RE = 13'(PADDLE_L_X + PADDLE_W);
    localparam logic signed [12:0] PAD_R_LE = 13'(PADDLE_R_X);
    localparam logic        [7:0]  SERVE_N  = 8'(SERVE_FRAMES);
    localparam logic        [3:0]  WIN_N    = 4'(WIN_SCORE);

    state_t     state_q;
    logic       start_q;
    logic       start_pend;
    logic [7:0] serve_cnt;

    assign state = state_q;

    // All position maths in signed 13 bits so that sums cannot overflow.
    logic signed [12:0] bx, by, pl, pr;
    assign bx = {{2{ball_x[10]}}, ball_x};
    assign by = {{2{ball_y[10]}}, ball_y};
    assign pl = {3'b000, paddle_l_y};
    assign pr = {3'b000, paddle_r_y};

    logic hit_top, hit_bot, ovl_l, ovl_r, hit_l, hit_r, miss_l, miss_r;
    logic game_won, go_serve;

    assign hit_top = ball_dir[3] && (by <= 13'sd0);
    assign hit_bot = ball_dir[2] && ((by + BALL) >= SCR_H);
    assign ovl_l   = ((by + BALL) > pl) && (by < (pl + PAD_H));
    assign ovl_r   = ((by + BALL) > pr) && (by < (pr + PAD_H));
    assign hit_l   = ball_dir[1] && (bx <= PAD_L_RE) && ovl_l;
    assign hit_r   = ball_dir[0] && ((bx + BALL) >= PAD_R_LE) && ovl_r;
    // A ball that reaches the paddle column but also the wall is still a hit.
    assign miss_l  = ball_dir[1] && !hit_l && (bx <= 13'sd0);
    assign miss_r  = ball_dir[0] && !hit_r && ((bx + BALL) >= SCR_W);

    assign game_won = (score_l == WIN_N) || (score_r == WIN_N);
    assign go_serve = frame_tick &&
                      ((((state_q == ST_IDLE) || (state_q == ST_OVER)) && start_pend) ||
                       ((state_q == ST_POINT) && !game_won));

`ifdef PONG_SPEEDUP_EN
    logic [3:0] rally;
    assign ball_speed = rally[3:2];
`else
    assign ball_speed = 2'd0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ball_rst   <= 1'b0;
            ball_move  <= 1'b0;
            ball_dir   <= 4'b0101;
            score_l    <= 4'd0;
            score_r    <= 4'd0;
            winner     <= 1'b0;
            start_pend <= 1'b0;
            serve_cnt  <= 8'd0;
            // Treat the button as already high so a level held through reset
            // does not look like a press.
            start_q    <= 1'b1;
`ifdef PONG_SPEEDUP_EN
            rally      <= 4'd0;
`endif
        end else begin
            start_q  <= start_btn;
            ball_rst <= 1'b0;

            if ((state_q != ST_IDLE) && (state_q != ST_OVER))
                start_pend <= 1'b0;
            else if (start_btn && !start_q)
                start_pend <= 1'b1;

            if (frame_tick) begin
                case (state_q)
                    ST_IDLE: begin
                        ball_move <= 1'b0;
                        if (start_pend)
                            start_pend <= 1'b0;
                    end
                    ST_OVER: begin
                        ball_move <= 1'b0;
                        if (start_pend) begin
                            start_pend <= 1'b0;
                            score_l    <= 4'd0;
                            score_r    <= 4'd0;
                        end
                    end
                    ST_SERVE: begin
                        if (serve_cnt <= 8'd1) begin
                            serve_cnt <= 8'd0;
                            state_q   <= ST_PLAY;
                            ball_move <= 1'b1;
                        end else begin
                            serve_cnt <= serve_cnt - 8'd1;
                        end
                    end
                    ST_PLAY: begin
                        if (hit_top)
                            ball_dir[3:2] <= 2'b01;
                        else if (hit_bot)
                            ball_dir[3:2] <= 2'b10;

                        if (hit_l || hit_r) begin
                            ball_dir[1:0] <= hit_l ? 2'b01 : 2'b10;
`ifdef PONG_SPEEDUP_EN
                            if (rally != 4'hF)
                                rally <= rally + 4'd1;
`endif
                        end else if (miss_l || miss_r) begin
                            // winner tracks the last scorer; it is only
                            // meaningful to the outside once in OVER.
                            if (miss_l && (score_r != 4'hF))
                                score_r <= score_r + 4'd1;
                            if (miss_r && (score_l != 4'hF))
                                score_l <= score_l + 4'd1;
                            winner    <= miss_l;
                            ball_move <= 1'b0;
                            state_q   <= ST_POINT;
                        end
                    end
                    ST_POINT: begin
                        ball_move <= 1'b0;
                        if (game_won)
                            state_q <= ST_OVER;
                        else
                            // Serve toward the player who conceded.
                            ball_dir[1:0] <= winner ? 2'b10 : 2'b01;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end

            if (go_serve) begin
                state_q   <= ST_SERVE;
                ball_rst  <= 1'b1;
                serve_cnt <= SERVE_N;
`ifdef PONG_SPEEDUP_EN
                rally     <= 4'd0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
module tb_pong_game_ctrl;

    logic               clk_50 = 1'b0;
    logic               reset;
    logic               frame_tick;
    logic               start_btn;
    logic signed [10:0] ball_x;
    logic signed [10:0] ball_y;
    logic        [9:0]  paddle_l_y;
    logic        [9:0]  paddle_r_y;
    logic               ball_rst;
    logic               ball_move;
    logic        [3:0]  ball_dir;
    logic        [1:0]  ball_speed;
    logic        [3:0]  score_l;
    logic        [3:0]  score_r;
    logic        [2:0]  state;
    logic               winner;

    pong_game_ctrl dut (
        .clk        (clk_50),
        .reset      (reset),
        .frame_tick (frame_tick),
        .start_btn  (start_btn),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .paddle_l_y (paddle_l_y),
        .paddle_r_y (paddle_r_y),
        .ball_rst   (ball_rst),
        .ball_move  (ball_move),
        .ball_dir   (ball_dir),
        .ball_speed (ball_speed),
        .score_l    (score_l),
        .score_r    (score_r),
        .state      (state),
        .winner     (winner)
    );

    always #10 clk_50 = ~clk_50;

    int checks = 0;
    int errors = 0;

    // Reference model: game quantities as plain integers, ball heading as +/-1.
    int m_state;   // 0 IDLE 1 SERVE 2 PLAY 3 POINT 4 OVER
    int m_dx;      // +1 right, -1 left
    int m_dy;      // +1 down,  -1 up
    int m_sl, m_sr, m_scorer, m_pend, m_frames, m_rally, m_move, m_rst;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] m_dir();
        logic [3:0] d;
        d[0] = (m_dx > 0);
        d[1] = (m_dx < 0);
        d[2] = (m_dy > 0);
        d[3] = (m_dy < 0);
        return d;
    endfunction

    function automatic int m_speed();
`ifdef PONG_SPEEDUP_EN
        return m_rally / 4;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_state = 0; m_dx = 1; m_dy = 1; m_sl = 0; m_sr = 0; m_scorer = 0;
        m_pend = 0; m_frames = 0; m_rally = 0; m_move = 0; m_rst = 0;
    endtask

    task automatic model_serve();
        m_state = 1; m_rst = 1; m_frames = 60; m_rally = 0;
    endtask

    task automatic model_tick();
        int bx, by, pl, pr;
        bx = ball_x; by = ball_y; pl = paddle_l_y; pr = paddle_r_y;
        case (m_state)
            0: if (m_pend) begin m_pend = 0; model_serve(); end
            4: if (m_pend) begin m_pend = 0; m_sl = 0; m_sr = 0; model_serve(); end
            1: begin
                m_frames--;
                if (m_frames == 0) begin m_state = 2; m_move = 1; end
            end
            2: begin
                if (m_dy < 0 && by <= 0) m_dy = 1;
                else if (m_dy > 0 && by + 20 >= 480) m_dy = -1;
                if (m_dx < 0) begin
                    if (bx <= 30 && by + 20 > pl && by < pl + 80) begin
                        m_dx = 1; m_rally = (m_rally < 15) ? m_rally + 1 : 15;
                    end else if (bx <= 0) begin
                        m_sr = (m_sr < 15) ? m_sr + 1 : 15; m_scorer = 1; m_state = 3; m_move = 0;
                    end
                end else begin
                    if (bx + 20 >= 610 && by + 20 > pr && by < pr + 80) begin
                        m_dx = -1; m_rally = (m_rally < 15) ? m_rally + 1 : 15;
                    end else if (bx + 20 >= 640) begin
                        m_sl = (m_sl < 15) ? m_sl + 1 : 15; m_scorer = 0; m_state = 3; m_move = 0;
                    end
                end
            end
            3: begin
                if (m_sl == 9 || m_sr == 9) m_state = 4;
                else begin m_dx = m_scorer ? -1 : 1; model_serve(); end
            end
            default: ;
        endcase
    endtask

    task automatic check_model();
        chk("state", state, m_state);
        chk("ball_move", ball_move, m_move);
        chk("ball_dir", ball_dir, m_dir());
        chk("score_l", score_l, m_sl);
        chk("score_r", score_r, m_sr);
        chk("ball_speed", ball_speed, m_speed());
        if (m_state == 4) chk("winner", winner, m_scorer);
    endtask

    task automatic check_reset_vals();
        chk("rst_state", state, 0);
        chk("rst_ball_rst", ball_rst, 0);
        chk("rst_ball_move", ball_move, 0);
        chk("rst_ball_dir", ball_dir, 4'b0101);
        chk("rst_ball_speed", ball_speed, 0);
        chk("rst_score_l", score_l, 0);
        chk("rst_score_r", score_r, 0);
        chk("rst_winner", winner, 0);
    endtask

    // Called at a falling edge: one tick cycle, then one idle cycle in which
    // nothing may change except ball_rst dropping.
    task automatic tick(input int bx, input int by, input int pl, input int pr);
        logic [31:0] v;
        v = bx; ball_x = v[10:0];
        v = by; ball_y = v[10:0];
        v = pl; paddle_l_y = v[9:0];
        v = pr; paddle_r_y = v[9:0];
        frame_tick = 1'b1;
        @(negedge clk_50);
        frame_tick = 1'b0;
        model_tick();
        check_model();
        chk("ball_rst", ball_rst, m_rst);
        m_rst = 0;
        @(negedge clk_50);
        chk("ball_rst_pulse", ball_rst, 0);
        check_model();
    endtask

    task automatic press_start();
        start_btn = 1'b1;
        @(negedge clk_50);
        start_btn = 1'b0;
        @(negedge clk_50);
        if (m_state == 0 || m_state == 4) m_pend = 1;
    endtask

    task automatic serve_through();
        repeat (60) tick(300, 200, 0, 0);
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; start_btn = 1'b1;
        ball_x = 11'sd300; ball_y = 11'sd200; paddle_l_y = 10'd0; paddle_r_y = 10'd0;
        model_reset();
        #25;
        check_reset_vals();
        @(negedge clk_50);
        reset = 1'b0;

        // Button held through reset must not start a game.
        repeat (3) tick(300, 200, 0, 0);
        start_btn = 1'b0;
        @(negedge clk_50);

        // Start, 60 serve frames, then play.
        press_start();
        tick(300, 200, 0, 0);
        chk("serve_entered", state, 1);
        serve_through();
        chk("play_after_serve", state, 2);
        chk("move_in_play", ball_move, 1);

        // Bottom then top wall bounce.
        tick(300, 460, 0, 0);
        tick(300, 0, 0, 0);
        chk("top_bounce_vert", ball_dir[3:2], 2'b01);
        chk("top_bounce_horiz", ball_dir[1:0], 2'b01);

        // Right paddle hit, left paddle hit, then a left miss.
        tick(590, 100, 0, 90);
        tick(30, 100, 90, 0);
        chk("left_hit_dir", ball_dir[1:0], 2'b01);
        chk("left_hit_score", score_r, 0);
        tick(590, 100, 0, 90);
        tick(0, 100, 300, 0);
        chk("left_miss_score", score_r, 1);
        chk("left_miss_state", state, 3);
        tick(300, 200, 0, 0);
        chk("serve_toward_left", ball_dir[1:0], 2'b10);
        serve_through();

        // Corner: bottom wall and right paddle in the same tick.
        tick(30, 100, 90, 0);
        tick(620, 460, 0, 450);
        chk("corner_dir", ball_dir, 4'b1010);

        // Left player scores until the game ends.
        for (int i = 0; i < 9; i++) begin
            if (m_dx < 0) tick(30, 200, 160, 0);
            if (i == 8) chk("score_l_before_win", score_l, 8);
            tick(640, 300, 0, 0);
            tick(300, 200, 0, 0);
            if (i < 8) serve_through();
        end
        chk("over_state", state, 4);
        chk("over_winner", winner, 0);
        press_start();
        tick(300, 200, 0, 0);
        chk("restart_score_l", score_l, 0);
        chk("restart_score_r", score_r, 0);
        chk("restart_state", state, 1);
        serve_through();

        // Asynchronous reset in the middle of a clock phase.
        #3 reset = 1'b1;
        #1 check_reset_vals();
        model_reset();
        @(negedge clk_50);
        reset = 1'b0;
        @(negedge clk_50);

        // Four paddle hits in one rally.
        press_start();
        tick(300, 200, 0, 0);
        serve_through();
        repeat (2) begin
            tick(590, 200, 0, 180);
            tick(30, 200, 180, 0);
        end
`ifdef PONG_SPEEDUP_EN
        chk("speed_after_4_hits", ball_speed, 1);
`else
        chk("speed_after_4_hits", ball_speed, 0);
`endif

        // Random play against the model.
        for (int n = 0; n < 2500; n++) begin
            if ((m_state == 0 || m_state == 4) && $urandom_range(0, 3) == 0) press_start();
            tick(int'($urandom_range(0, 680)) - 20, int'($urandom_range(0, 500)) - 20,
                 int'($urandom_range(0, 400)), int'($urandom_range(0, 400)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
